// File: rtl/vid_pkg.sv
// Width constants shared by the video pipeline stages, plus the 8-bit
// saturation helper used where the gradient magnitude leaves the pipeline.
package vid_pkg;

  localparam int PIX_W  = 8;
  localparam int X_W    = 11;
  localparam int Y_W    = 10;
  localparam int GSUM_W = 10;
  localparam int GMAG_W = 11;

  function automatic logic [PIX_W-1:0] sat_pix(input logic [GMAG_W-1:0] v);
    if (v[GMAG_W-1:PIX_W] != '0) begin
      sat_pix = {PIX_W{1'b1}};
    end else begin
      sat_pix = v[PIX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/sobel_edge_detect_3x3_if.sv
// Pixel stream bundle between the 3x3 matrix generator and the edge detector:
// window taps, strobes and coordinates in, edge pixel stream out.
interface sobel_edge_detect_3x3_if;
  import vid_pkg::*;

  logic             per_frame_vsync;
  logic             per_frame_href;
  logic             per_frame_clken;
  logic [PIX_W-1:0] matrix_p11, matrix_p12, matrix_p13;
  logic [PIX_W-1:0] matrix_p21, matrix_p22, matrix_p23;
  logic [PIX_W-1:0] matrix_p31, matrix_p32, matrix_p33;
  logic [X_W-1:0]   per_setx;
  logic [Y_W-1:0]   per_sety;

  logic             post_frame_vsync;
  logic             post_frame_href;
  logic             post_frame_clken;
  logic             post_img_bit;
  logic [PIX_W-1:0] post_img_mag;
  logic [X_W-1:0]   post_setx;
  logic [Y_W-1:0]   post_sety;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken,
    output matrix_p11, matrix_p12, matrix_p13,
    output matrix_p21, matrix_p22, matrix_p23,
    output matrix_p31, matrix_p32, matrix_p33,
    output per_setx, per_sety,
    input  post_frame_vsync, post_frame_href, post_frame_clken,
    input  post_img_bit, post_img_mag, post_setx, post_sety
  );

  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken,
    input  matrix_p11, matrix_p12, matrix_p13,
    input  matrix_p21, matrix_p22, matrix_p23,
    input  matrix_p31, matrix_p32, matrix_p33,
    input  per_setx, per_sety,
    output post_frame_vsync, post_frame_href, post_frame_clken,
    output post_img_bit, post_img_mag, post_setx, post_sety
  );

endinterface

// File: rtl/abs_diff_u10.sv
// Unsigned absolute difference of two partial Sobel sums; never wraps.
module abs_diff_u10
  import vid_pkg::*;
(
  input  logic [GSUM_W-1:0] a_i,
  input  logic [GSUM_W-1:0] b_i,
  output logic [GSUM_W-1:0] diff_o
);

  // Subtract the smaller operand from the larger one
  always_comb begin
    if (a_i >= b_i) begin
      diff_o = a_i - b_i;
    end else begin
      diff_o = b_i - a_i;
    end
  end

endmodule

// File: rtl/sobel_edge_detect_3x3.sv
// Three-stage Sobel edge detector (|Gx|+|Gy|) with threshold, border masking,
// centre-aligned coordinates and a saturating per-frame edge-pixel counter.
module sobel_edge_detect_3x3
  import vid_pkg::*;
#(
  parameter int IMG_HDISP = 1280,
  parameter int IMG_VDISP = 720,
  parameter int CNT_W     = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  sobel_edge_detect_3x3_if.slave vif,
  input  logic [PIX_W-1:0]       threshold,
  output logic [CNT_W-1:0]       edge_count,
  output logic                   count_valid
);

  if (IMG_HDISP < 3 || IMG_HDISP > (1 << X_W) || IMG_VDISP < 3 ||
      IMG_VDISP > (1 << Y_W) || (2.0 ** CNT_W) < (IMG_HDISP * 1.0 * IMG_VDISP)) begin : g_bad_cfg
    $error("sobel_edge_detect_3x3: frame size does not fit coordinate or counter widths");
  end

  logic [GSUM_W-1:0] gxp_d, gxn_d, gyp_d, gyn_d;
  logic [GSUM_W-1:0] gxp_q, gxn_q, gyp_q, gyn_q;
  logic [GSUM_W-1:0] adx_s, ady_s;
  logic              win1_d, win1_q, win2_q;
  logic [X_W-1:0]    x1_d, x1_q, x2_q, x3_q;
  logic [Y_W-1:0]    y1_d, y1_q, y2_q, y3_q;
  logic [2:0]        strb1_q, strb2_q, strb3_q;
  logic [GMAG_W-1:0] sum_d, sum_q;
  logic [PIX_W-1:0]  thr_q, mag_d, mag_q;
  logic              bit_d, bit_q;
  logic [CNT_W-1:0]  acc_d, acc_q, edge_count_d, edge_count_q;
  logic              count_valid_d, count_valid_q, vs_prev_q;
  logic              vs_rise_s, incr_s;

  // Stage 1: weighted partial sums, border flag and centre coordinates
  always_comb begin
    gxp_d  = GSUM_W'(vif.matrix_p13) + GSUM_W'({vif.matrix_p23, 1'b0}) + GSUM_W'(vif.matrix_p33);
    gxn_d  = GSUM_W'(vif.matrix_p11) + GSUM_W'({vif.matrix_p21, 1'b0}) + GSUM_W'(vif.matrix_p31);
    gyp_d  = GSUM_W'(vif.matrix_p31) + GSUM_W'({vif.matrix_p32, 1'b0}) + GSUM_W'(vif.matrix_p33);
    gyn_d  = GSUM_W'(vif.matrix_p11) + GSUM_W'({vif.matrix_p12, 1'b0}) + GSUM_W'(vif.matrix_p13);
    win1_d = (vif.per_setx >= X_W'(2'd2)) && (vif.per_sety >= Y_W'(2'd2));
    x1_d   = (vif.per_setx == '0) ? '0 : vif.per_setx - X_W'(1'b1);
    y1_d   = (vif.per_sety == '0) ? '0 : vif.per_sety - Y_W'(1'b1);
  end

  abs_diff_u10 u_abs_x (.a_i(gxp_q), .b_i(gxn_q), .diff_o(adx_s));
  abs_diff_u10 u_abs_y (.a_i(gyp_q), .b_i(gyn_q), .diff_o(ady_s));

  // Stages 2 and 3: magnitude sum, then saturation and thresholding
  always_comb begin
    sum_d = GMAG_W'(adx_s) + GMAG_W'(ady_s);
    mag_d = '0;
    bit_d = 1'b0;
    if (win2_q) begin
      mag_d = sat_pix(sum_q);
      bit_d = (sum_q >= GMAG_W'(thr_q));
    end else begin
      mag_d = '0;
      bit_d = 1'b0;
    end
  end

  assign vs_rise_s = strb3_q[2] && !vs_prev_q;
  assign incr_s    = strb3_q[0] && bit_q;

  // Frame accumulator: a pixel landing on the vsync rise opens the new frame
  always_comb begin
    acc_d         = acc_q;
    edge_count_d  = edge_count_q;
    count_valid_d = 1'b0;
    if (vs_rise_s) begin
      edge_count_d  = acc_q;
      count_valid_d = 1'b1;
      acc_d         = incr_s ? CNT_W'(1'b1) : '0;
    end else if (incr_s && (acc_q != {CNT_W{1'b1}})) begin
      acc_d = acc_q + CNT_W'(1'b1);
    end else begin
      acc_d = acc_q;
    end
  end

  // Pipeline and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      gxp_q <= '0; gxn_q <= '0; gyp_q <= '0; gyn_q <= '0;
      win1_q <= 1'b0; win2_q <= 1'b0;
      x1_q <= '0; x2_q <= '0; x3_q <= '0;
      y1_q <= '0; y2_q <= '0; y3_q <= '0;
      strb1_q <= '0; strb2_q <= '0; strb3_q <= '0;
      sum_q <= '0; thr_q <= '0; mag_q <= '0; bit_q <= 1'b0;
      acc_q <= '0; edge_count_q <= '0; count_valid_q <= 1'b0; vs_prev_q <= 1'b0;
    end else begin
      gxp_q <= gxp_d; gxn_q <= gxn_d; gyp_q <= gyp_d; gyn_q <= gyn_d;
      win1_q <= win1_d; win2_q <= win1_q;
      x1_q <= x1_d; x2_q <= x1_q; x3_q <= x2_q;
      y1_q <= y1_d; y2_q <= y1_q; y3_q <= y2_q;
      strb1_q <= {vif.per_frame_vsync, vif.per_frame_href, vif.per_frame_clken};
      strb2_q <= strb1_q;
      strb3_q <= strb2_q;
      sum_q <= sum_d; thr_q <= threshold; mag_q <= mag_d; bit_q <= bit_d;
      acc_q <= acc_d; edge_count_q <= edge_count_d; count_valid_q <= count_valid_d;
      vs_prev_q <= strb3_q[2];
    end
  end

  assign vif.post_frame_vsync = strb3_q[2];
  assign vif.post_frame_href  = strb3_q[1];
  assign vif.post_frame_clken = strb3_q[0];
  assign vif.post_img_bit     = bit_q;
  assign vif.post_img_mag     = mag_q;
  assign vif.post_setx        = x3_q;
  assign vif.post_sety        = y3_q;
  assign edge_count           = edge_count_q;
  assign count_valid          = count_valid_q;

endmodule

// File: tb/tb_sobel_edge_detect_3x3.sv
// Scoreboard bench: directed windows with hand-computed results are queued at
// issue time; a negedge monitor pops and compares whenever the DUT emits.
module tb_sobel_edge_detect_3x3;

  typedef struct packed {
    logic [8:0][7:0] t;     // t[0]=p11 ... t[8]=p33
    logic [10:0]     x;
    logic [9:0]      y;
    logic [7:0]      thr;
    logic [7:0]      mag;
    logic            bit_e;
    logic [10:0]     ex;
    logic [9:0]      ey;
  } vec_t;

  typedef struct {
    logic        b;
    logic [7:0]  mag;
    logic [10:0] x;
    logic [9:0]  y;
    int          cyc;
  } exp_t;

  typedef struct {
    int cnt;
    int cyc;
  } cexp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  threshold;
  logic [19:0] edge_count;
  logic        count_valid;

  sobel_edge_detect_3x3_if vif ();

  sobel_edge_detect_3x3 #(.IMG_HDISP(1280), .IMG_VDISP(720), .CNT_W(20)) dut (
    .clk(clk), .rst(rst), .vif(vif), .threshold(threshold),
    .edge_count(edge_count), .count_valid(count_valid)
  );

  always #5 clk = ~clk;

  int    cyc = 0;
  int    n_checks = 0;
  int    n_errors = 0;
  bit    done = 1'b0;
  exp_t  exp_q[$];
  cexp_t cexp_q[$];
  int    acc_m = 0;
  logic  prev_vs_m = 1'b0;
  vec_t  tbl[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input logic [7:0] a11, a12, a13, a21, a22, a23, a31, a32, a33,
                              input logic [10:0] x, input logic [9:0] y, input logic [7:0] thr,
                              input logic [7:0] mag, input logic b,
                              input logic [10:0] ex, input logic [9:0] ey);
    vec_t v;
    v.t = {a33, a32, a31, a23, a22, a21, a13, a12, a11};
    v.x = x; v.y = y; v.thr = thr; v.mag = mag; v.bit_e = b; v.ex = ex; v.ey = ey;
    return v;
  endfunction

  task automatic drive(input vec_t v, input logic vs, input logic ce);
    exp_t e;
    vif.per_frame_vsync = vs;
    vif.per_frame_href  = ce;
    vif.per_frame_clken = ce;
    vif.matrix_p11 = v.t[0]; vif.matrix_p12 = v.t[1]; vif.matrix_p13 = v.t[2];
    vif.matrix_p21 = v.t[3]; vif.matrix_p22 = v.t[4]; vif.matrix_p23 = v.t[5];
    vif.matrix_p31 = v.t[6]; vif.matrix_p32 = v.t[7]; vif.matrix_p33 = v.t[8];
    vif.per_setx = v.x;
    vif.per_sety = v.y;
    if (ce) begin
      threshold = v.thr;
      e.b = v.bit_e; e.mag = v.mag; e.x = v.ex; e.y = v.ey; e.cyc = cyc + 3;
      exp_q.push_back(e);
    end
    if (vs && !prev_vs_m) begin
      cexp_q.push_back('{acc_m, cyc + 4});
      acc_m = (ce && v.bit_e) ? 1 : 0;
    end else if (ce && v.bit_e) begin
      acc_m++;
    end
    prev_vs_m = vs;
    @(posedge clk); #1;
  endtask

  task automatic hold_reset(input int n);
    vec_t z;
    z = '0;
    rst = 1'b1;
    vif.per_frame_vsync = 1'b0; vif.per_frame_href = 1'b0; vif.per_frame_clken = 1'b0;
    vif.matrix_p11 = z.t[0]; vif.matrix_p12 = z.t[1]; vif.matrix_p13 = z.t[2];
    vif.matrix_p21 = z.t[3]; vif.matrix_p22 = z.t[4]; vif.matrix_p23 = z.t[5];
    vif.matrix_p31 = z.t[6]; vif.matrix_p32 = z.t[7]; vif.matrix_p33 = z.t[8];
    vif.per_setx = '0; vif.per_sety = '0;
    repeat (n) begin @(posedge clk); #1; end
    rst = 1'b0;
    acc_m = 0;
    prev_vs_m = 1'b0;
  endtask

  // Stimulus
  initial begin
    vec_t idle, vs_step, unif;
    idle = '0;
    threshold = 8'd64;
    hold_reset(3);

    vs_step = mk(0, 0, 255, 0, 0, 255, 0, 0, 255, 10, 10, 64, 255, 1, 9, 9);
    unif    = mk(100, 100, 100, 100, 100, 100, 100, 100, 100, 10, 10, 64, 0, 0, 9, 9);
    tbl.push_back(unif);
    tbl.push_back(vs_step);
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 255, 255, 255, 20, 5, 64, 255, 1, 19, 4));
    tbl.push_back(mk(0, 0, 16, 0, 0, 16, 0, 0, 16, 30, 7, 64, 64, 1, 29, 6));
    tbl.push_back(mk(0, 0, 16, 0, 0, 16, 0, 0, 16, 30, 7, 65, 64, 0, 29, 6));
    tbl.push_back(mk(0, 0, 50, 0, 0, 50, 0, 0, 50, 40, 8, 64, 200, 1, 39, 7));
    tbl.push_back(mk(255, 0, 0, 255, 0, 0, 255, 0, 0, 12, 3, 64, 255, 1, 11, 2));
    tbl.push_back(mk(200, 0, 0, 0, 0, 0, 0, 0, 0, 15, 15, 64, 255, 1, 14, 14));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 50, 9, 64, 4, 0, 49, 8));
    tbl.push_back(mk(0, 0, 255, 0, 0, 255, 0, 0, 255, 1, 10, 64, 0, 0, 0, 9));
    tbl.push_back(mk(0, 0, 255, 0, 0, 255, 0, 0, 255, 10, 0, 64, 0, 0, 9, 0));
    tbl.push_back(mk(0, 0, 255, 0, 0, 255, 0, 0, 255, 0, 0, 64, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 255, 0, 0, 255, 0, 0, 255, 2, 2, 64, 255, 1, 1, 1));
    tbl.push_back(mk(100, 100, 100, 100, 100, 100, 100, 100, 100, 5, 5, 0, 0, 1, 4, 4));
    tbl.push_back(mk(0, 0, 255, 0, 0, 255, 0, 0, 255, 60, 20, 255, 255, 1, 59, 19));
    tbl.push_back(mk(0, 0, 50, 0, 0, 50, 0, 0, 50, 70, 20, 255, 200, 0, 69, 19));

    foreach (tbl[i]) begin
      drive(tbl[i], 1'b0, 1'b1);
      drive(idle, 1'b0, 1'b0);
    end
    threshold = 8'd64;
    repeat (4) drive(idle, 1'b0, 1'b0);
    // Close the frame holding the table pixels
    repeat (2) drive(idle, 1'b1, 1'b0);
    repeat (2) drive(idle, 1'b0, 1'b0);

    // Frame of 10 edge pixels and 5 flat pixels
    for (int i = 0; i < 10; i++) begin
      vs_step.x = 11'(100 + i); vs_step.ex = 11'(99 + i);
      drive(vs_step, 1'b0, 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      unif.x = 11'(200 + i); unif.ex = 11'(199 + i);
      drive(unif, 1'b0, 1'b1);
    end
    drive(idle, 1'b0, 1'b0);
    repeat (2) drive(idle, 1'b1, 1'b0);
    repeat (2) drive(idle, 1'b0, 1'b0);

    // Edge pixel coincident with the vsync rise opens the next frame
    vs_step.x = 11'd10; vs_step.ex = 11'd9;
    repeat (2) drive(vs_step, 1'b0, 1'b1);
    drive(vs_step, 1'b1, 1'b1);
    drive(idle, 1'b1, 1'b0);
    repeat (2) drive(idle, 1'b0, 1'b0);
    drive(vs_step, 1'b0, 1'b1);
    drive(idle, 1'b0, 1'b0);
    repeat (2) drive(idle, 1'b1, 1'b0);
    repeat (6) drive(idle, 1'b0, 1'b0);

    // Reset in the middle of a frame
    repeat (4) drive(vs_step, 1'b0, 1'b1);
    repeat (6) drive(idle, 1'b0, 1'b0);
    hold_reset(3);
    repeat (3) drive(vs_step, 1'b0, 1'b1);
    drive(idle, 1'b0, 1'b0);
    repeat (2) drive(idle, 1'b1, 1'b0);
    repeat (8) drive(idle, 1'b0, 1'b0);
    done = 1'b1;
  end

  // Monitor and scoreboard
  initial begin
    logic  rst_prev;
    exp_t  e;
    cexp_t c;
    rst_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && rst_prev) begin
        n_checks++;
        if ({vif.post_frame_vsync, vif.post_frame_href, vif.post_frame_clken, vif.post_img_bit,
             vif.post_img_mag, vif.post_setx, vif.post_sety, edge_count, count_valid} != '0) begin
          n_errors++;
          $display("FAIL reset_outputs cyc=%0d: vs=%b hr=%b ce=%b bit=%b mag=%0d x=%0d y=%0d cnt=%0d cv=%b, required all 0",
                   cyc, vif.post_frame_vsync, vif.post_frame_href, vif.post_frame_clken, vif.post_img_bit,
                   vif.post_img_mag, vif.post_setx, vif.post_sety, edge_count, count_valid);
        end
      end else if (!rst) begin
        if (vif.post_frame_clken) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL pixel_unexpected cyc=%0d: output pixel with nothing expected", cyc);
          end else begin
            e = exp_q.pop_front();
            if (vif.post_img_bit !== e.b || vif.post_img_mag !== e.mag || vif.post_setx !== e.x ||
                vif.post_sety !== e.y || vif.post_frame_href !== 1'b1 || cyc != e.cyc) begin
              n_errors++;
              $display("FAIL pixel cyc=%0d: bit=%b mag=%0d x=%0d y=%0d href=%b, required bit=%b mag=%0d x=%0d y=%0d href=1 at cyc=%0d",
                       cyc, vif.post_img_bit, vif.post_img_mag, vif.post_setx, vif.post_sety,
                       vif.post_frame_href, e.b, e.mag, e.x, e.y, e.cyc);
            end
          end
        end
        if (count_valid) begin
          n_checks++;
          if (cexp_q.size() == 0) begin
            n_errors++;
            $display("FAIL count_unexpected cyc=%0d: count_valid with edge_count=%0d", cyc, edge_count);
          end else begin
            c = cexp_q.pop_front();
            if (edge_count != 20'(c.cnt) || cyc != c.cyc) begin
              n_errors++;
              $display("FAIL edge_count cyc=%0d: edge_count=%0d, required %0d at cyc=%0d",
                       cyc, edge_count, c.cnt, c.cyc);
            end
          end
        end
      end
      rst_prev = rst;
      if (done || cyc > 5000) begin
        n_checks++;
        if (!done || exp_q.size() != 0 || cexp_q.size() != 0) begin
          n_errors++;
          $display("FAIL drain cyc=%0d: done=%b pixels_left=%0d counts_left=%0d, required done=1 and 0 left",
                   cyc, done, exp_q.size(), cexp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
      end
    end
  end

endmodule

// File: doc/sobel_edge_detect_3x3.md
# sobel_edge_detect_3x3

Pipelined Sobel edge detector that sits directly downstream of the 3×3 matrix generator in the video processing chain. It consumes the nine 8-bit window taps, the sync/enable strobes and the pixel coordinates, and computes the approximate gradient magnitude |Gx|+|Gy|. It produces a thresholded binary edge pixel with a saturated 8-bit magnitude and realigned coordinates. It also keeps a per-frame edge-pixel count for the downstream target-localisation logic.

## Interface
- `IMG_HDISP`, default 1280: active pixels per line. Used only by the bench and by coordinate sanity checks.
- `IMG_VDISP`, default 720: active lines per frame.
- `CNT_W`, default 20: width of the edge counter. 2^20 ≥ 1280×720.
- `clk`  in  1  pixel clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `per_frame_vsync`, `per_frame_href`, `per_frame_clken`  in  1 each  strobes from the matrix stage.
- `matrix_p11` … `matrix_p33`  in  8 each  window taps. Row 1 is the oldest line; column 3 is the newest pixel.
- `per_setx`  in  11  column of the newest pixel, aligned with the taps.
- `per_sety`  in  10  row of the newest pixel, aligned with the taps.
- `threshold`  in  8  edge threshold, sampled every cycle.
- `post_frame_vsync`, `post_frame_href`, `post_frame_clken`  out  1 each  strobes delayed by 3 cycles.
- `post_img_bit`  out  1  edge flag for the window centre.
- `post_img_mag`  out  8  gradient magnitude, saturated at 255.
- `post_setx`  out  11  column of the window centre.
- `post_sety`  out  10  row of the window centre.
- `edge_count`  out  CNT_W  edge pixels counted in the last completed frame.
- `count_valid`  out  1  one-cycle pulse when `edge_count` updates.

## Operation
- **S1 (registered):**
  - `gx_p = p13 + 2·p23 + p33`, `gx_n = p11 + 2·p21 + p31`.
  - `gy_p = p31 + 2·p32 + p33`, `gy_n = p11 + 2·p12 + p13`.
  - All four sums are 10-bit unsigned (maximum 1020).
  - `win_ok = (per_setx ≥ 2) && (per_sety ≥ 2)`.
  - Coordinates are converted to the centre: `per_setx−1`, `per_sety−1`, each clamped at 0.
- **S2 (registered):** `sum = |gx_p−gx_n| + |gy_p−gy_n|`, 11-bit unsigned (maximum 2040). No wraparound is permitted.
- **S3 (registered):**
  - `post_img_mag = (sum > 255) ? 255 : sum[7:0]`.
  - `post_img_bit = win_ok && (sum ≥ threshold)`. Equality counts as an edge.
  - `threshold` is sampled in S2 so it is aligned with `sum`.
- **Border masking:** when `win_ok` is 0, both `post_img_bit` and `post_img_mag` are forced to 0.
- **Data path gating:** the data path runs every cycle and is not gated by clken. Outputs are meaningful only while `post_frame_clken` is 1.
- **Edge counter:**
  - The accumulator increments when `post_frame_clken && post_img_bit` (evaluated at S3 output).
  - It saturates at 2^CNT_W−1.
- **Frame boundary:** on the rising edge of the internal S3 vsync:
  - `edge_count` is loaded with the accumulator.
  - `count_valid` pulses for 1 cycle.
  - The accumulator is cleared.
- **Simultaneous events:** if an edge pixel coincides with the vsync rise, `edge_count` takes the old total and the accumulator loads 1.

## Timing
- Latency is 3 cycles from input to output for all data, strobes and coordinates. Throughput is one pixel per clock.
- Reset values:
  - All outputs are 0, including `edge_count`, `count_valid` and the strobes.
  - Pipeline registers and the accumulator are 0.
  - The vsync edge detector's previous-value register is 0.
- Reset asserted mid-frame:
  - All state clears on the next clock edge.
  - The first `count_valid` after release reports only the pixels since release.
  - The first vsync rise seen after reset is treated as a normal frame boundary.
- `count_valid` asserts in the cycle after `post_frame_vsync` first reads 1, together with the new `edge_count`.

## Structure
- Shared package `vid_pkg` holds the width constants: `PIX_W=8`, `X_W=11`, `Y_W=10`, `GSUM_W=10`, `GMAG_W=11`.
- One sub-module, `abs_diff_u10`: a combinational |a−b| on 10-bit unsigned inputs. It is instantiated twice in S2.
- Everything else lives in the top-level `always` blocks.

## Test plan
- **Uniform field:** all taps 100, `threshold`=64, setx=10, sety=10 → `post_img_mag`=0, `post_img_bit`=0, `post_setx`=9, `post_sety`=9, 3 cycles later.
- **Vertical step:** columns 1 and 2 = 0, column 3 = 255 → `sum`=1020, so `post_img_mag`=255 and `post_img_bit`=1. Also check the horizontal counterpart, row 3 = 255.
- **Threshold equality:** p13=p23=p33=16, others 0 → `sum`=64. With `threshold`=64 the bit is 1; with 65 it is 0.
- **Border:** vertical-step window with setx=1 (and separately sety=0) → bit=0, mag=0, `post_setx`=0 (clamped), and no count increment.
- **Frame count:** send 10 edge pixels plus 5 non-edge pixels, then raise vsync → `count_valid` pulses once and `edge_count`=10. In the next frame, an edge pixel on the vsync-rise cycle is counted into the new frame.
- **Reset mid-frame:** assert `rst` after 4 edge pixels, then send 3 more and a vsync rise → `edge_count`=3. All outputs read 0 during reset.
